// File: rtl/des_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
// The grant vector type is sized for the largest supported requester count.
package des_pkg;

    localparam int MAX_REQ      = 8;
    localparam int RR_PTR_RESET = 0;

    typedef logic [MAX_REQ-1:0] gnt_vec_t;

    function automatic int clog2(input int value);
        int bits;
        int v;
        bits = 0;
        v    = value - 1;
        while (v > 0) begin
            bits++;
            v = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    // OR-ing the indices of set bits yields the index for a one-hot input.
    function automatic logic [2:0] onehot_to_idx(input gnt_vec_t v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (v[i]) idx = idx | 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import des_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic               any
);

    logic [PTR_W-1:0] idx;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[idx]) begin
                win[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter in front of a bank of enable-gated registers.
// Drives one registered, one-cycle write (or range error) per grant.
module reg_bank_write_arbiter
    import des_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int NUM_REGS = 8,
    parameter  int WIDTH    = 8,
    localparam int ADDR_W   = clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_data,
    input  logic                      freeze,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REGS-1:0]       reg_en,
    output logic [WIDTH-1:0]          reg_d,
    output logic                      err
);

    localparam int PTR_W = clog2(NUM_REQ);

    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    ptr_next;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  win;
    logic                any;
    logic [ADDR_W-1:0]   sel_addr;
    logic [WIDTH-1:0]    sel_data;
    logic                in_range;
    logic [NUM_REGS-1:0] dec;

    // A requester granted this cycle is still dropping req, so it sits out one round.
    assign eligible = req & ~gnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req (eligible),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        dec = '0;
        for (int j = 0; j < NUM_REGS; j++) begin
            dec[j] = (sel_addr == ADDR_W'(j));
        end
    end

    assign in_range = int'(sel_addr) < NUM_REGS;
    assign ptr_next = PTR_W'((int'(onehot_to_idx(gnt_vec_t'(win))) + 1) % NUM_REQ);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt    <= '0;
            reg_en <= '0;
            reg_d  <= '0;
            err    <= 1'b0;
            ptr    <= PTR_W'(RR_PTR_RESET);
        end else if (any && !freeze) begin
            gnt    <= win;
            reg_en <= in_range ? dec : '0;
            reg_d  <= in_range ? sel_data : '0;
            err    <= !in_range;
            ptr    <= ptr_next;
        end else begin
            gnt    <= '0;
            reg_en <= '0;
            reg_d  <= '0;
            err    <= 1'b0;
        end
    end

endmodule
